// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RISC-V control path: opcodes, ALU codes,
// write-back selects and the controller state encoding.
package riscv_pkg;

    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned ALU_CODE_W = 4;
    localparam int unsigned WB_SEL_W   = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IALU   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;

    localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 4'b0011;
    localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 4'b0100;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'b0111;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 4'b1000;
    localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 4'b1001;

    localparam logic [WB_SEL_W-1:0] WB_ALU = 2'd0;
    localparam logic [WB_SEL_W-1:0] WB_MEM = 2'd1;
    localparam logic [WB_SEL_W-1:0] WB_PC4 = 2'd2;
    localparam logic [WB_SEL_W-1:0] WB_IMM = 2'd3;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_LUI: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from opcode, funct3 and instruction bit 30.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [OPCODE_W-1:0]   opcode_i,
    input  logic [2:0]            funct3_i,
    input  logic                  funct7_5_i,
    output logic [ALU_CODE_W-1:0] alu_code_o
);

    always_comb begin
        alu_code_o = ALU_ADD;
        case (opcode_i)
            OP_RTYPE, OP_IALU: begin
                case (funct3_i)
                    // Bit 30 means SUB only for register-register ops; immediates reuse it as imm bits.
                    3'b000:  alu_code_o = (opcode_i == OP_RTYPE && funct7_5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_code_o = ALU_SLL;
                    3'b010:  alu_code_o = ALU_SLT;
                    3'b011:  alu_code_o = ALU_SLTU;
                    3'b100:  alu_code_o = ALU_XOR;
                    3'b101:  alu_code_o = funct7_5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_code_o = ALU_OR;
                    default: alu_code_o = ALU_AND;
                endcase
            end
            OP_BRANCH: begin
                case (funct3_i[2:1])
                    2'b10:   alu_code_o = ALU_SLT;
                    2'b11:   alu_code_o = ALU_SLTU;
                    default: alu_code_o = ALU_SUB;
                endcase
            end
            default: alu_code_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/wb with memory
// wait timeout and trap reporting for illegal opcodes and bus errors.
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W  = 4,
    parameter int unsigned MEM_TIMEOUT = 15
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  mem_ready,
    input  logic                  branch_taken,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  reg_write,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  alu_src_imm,
    output logic [1:0]            wb_sel,
    output logic [2:0]            state,
    output logic                  illegal_instr,
    output logic                  bus_error,
    output logic                  instr_retired
);

    localparam int unsigned CNT_W = 8;

    state_e                  state_q, state_d;
    logic [OPCODE_W-1:0]     op_q;
    logic [2:0]              f3_q;
    logic                    f7_q;
    logic [CNT_W-1:0]        wait_q, wait_d;
    logic                    trap_bus_q, trap_bus_d;
    logic [ALU_CODE_W-1:0]   alu_code;
    logic                    timeout_c;

    logic                    pc_write_c, ir_write_c, mem_req_c, mem_we_c, reg_write_c;
    logic [ALU_CODE_W-1:0]   alu_code_c;
    logic                    alu_src_imm_c;
    logic [WB_SEL_W-1:0]     wb_sel_c;
    logic                    illegal_c, bus_error_c, retired_c;

    alu_decoder u_alu_decoder (
        .opcode_i   (op_q),
        .funct3_i   (f3_q),
        .funct7_5_i (f7_q),
        .alu_code_o (alu_code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            wait_q     <= '0;
            op_q       <= '0;
            f3_q       <= '0;
            f7_q       <= 1'b0;
            trap_bus_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            trap_bus_q <= trap_bus_d;
            if (state_q == ST_DECODE) begin
                op_q <= opcode;
                f3_q <= funct3;
                f7_q <= funct7_5;
            end
        end
    end

    // A ready in the limit cycle still completes the access.
    assign timeout_c = (wait_q == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

    always_comb begin
        state_d       = state_q;
        trap_bus_d    = trap_bus_q;
        pc_write_c    = 1'b0;
        ir_write_c    = 1'b0;
        mem_req_c     = 1'b0;
        mem_we_c      = 1'b0;
        reg_write_c   = 1'b0;
        alu_code_c    = '0;
        alu_src_imm_c = 1'b0;
        wb_sel_c      = WB_ALU;
        illegal_c     = 1'b0;
        bus_error_c   = 1'b0;
        retired_c     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = ST_DECODE;
                end else if (timeout_c) begin
                    trap_bus_d = 1'b1;
                    state_d    = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (is_legal_op(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    trap_bus_d = 1'b0;
                    state_d    = ST_TRAP;
                end
            end
            ST_EXEC: begin
                alu_code_c    = alu_code;
                alu_src_imm_c = !(op_q == OP_RTYPE || op_q == OP_BRANCH);
                case (op_q)
                    OP_JAL: begin
                        pc_write_c = 1'b1;
                        state_d    = ST_WB;
                    end
                    OP_LOAD, OP_STORE: state_d = ST_MEM;
                    OP_BRANCH: begin
                        pc_write_c = branch_taken;
                        retired_c  = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (op_q == OP_STORE);
                if (mem_ready) begin
                    retired_c = (op_q == OP_STORE);
                    state_d   = (op_q == OP_STORE) ? ST_FETCH : ST_WB;
                end else if (timeout_c) begin
                    trap_bus_d = 1'b1;
                    state_d    = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_write_c = 1'b1;
                retired_c   = 1'b1;
                case (op_q)
                    OP_LOAD: wb_sel_c = WB_MEM;
                    OP_JAL:  wb_sel_c = WB_PC4;
                    OP_LUI:  wb_sel_c = WB_IMM;
                    default: wb_sel_c = WB_ALU;
                endcase
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                illegal_c   = !trap_bus_q;
                bus_error_c = trap_bus_q;
                state_d     = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Counter restarts on every state change, so each FETCH/MEM visit begins at zero.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_req_c) begin
            wait_d = wait_q + CNT_W'(1);
        end
    end

    // Reset suppresses every strobe, so an instruction cut off by reset never writes or retires.
    assign pc_write      = pc_write_c    & ~reset;
    assign ir_write      = ir_write_c    & ~reset;
    assign mem_req       = mem_req_c     & ~reset;
    assign mem_we        = mem_we_c      & ~reset;
    assign reg_write     = reg_write_c   & ~reset;
    assign alu_control   = reset ? '0 : ALU_CTRL_W'(alu_code_c);
    assign alu_src_imm   = alu_src_imm_c & ~reset;
    assign wb_sel        = reset ? WB_ALU : wb_sel_c;
    assign illegal_instr = illegal_c     & ~reset;
    assign bus_error     = bus_error_c   & ~reset;
    assign instr_retired = retired_c     & ~reset;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, reset-in-WB
// sequence and randomized instructions against a per-instruction trace model.
module tb_multicycle_control;

    localparam int unsigned MT  = 3;
    localparam int unsigned ACW = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic           funct7_5;
    logic           mem_ready;
    logic           branch_taken;
    logic           pc_write, ir_write, mem_req, mem_we, reg_write;
    logic [ACW-1:0] alu_control;
    logic           alu_src_imm;
    logic [1:0]     wb_sel;
    logic [2:0]     state;
    logic           illegal_instr, bus_error, instr_retired;

    always #5 clk = ~clk;

    multicycle_control #(.ALU_CTRL_W(ACW), .MEM_TIMEOUT(MT)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .mem_ready     (mem_ready),
        .branch_taken  (branch_taken),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .reg_write     (reg_write),
        .alu_control   (alu_control),
        .alu_src_imm   (alu_src_imm),
        .wb_sel        (wb_sel),
        .state         (state),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .instr_retired (instr_retired)
    );

    typedef struct packed {
        logic [2:0] state;
        logic       pc_write, ir_write, mem_req, mem_we, reg_write;
        logic [3:0] alu;
        logic       src_imm;
        logic [1:0] wb_sel;
        logic       illegal, bus, retired;
    } outs_t;

    typedef struct {
        logic  rdy;
        bit    any;
        outs_t exp;
    } cyc_t;

    typedef struct {
        int         cyc;
        logic [3:0] alu;
        logic [1:0] wb;
        int         regw, ret, ill, bus;
        logic       pcx;
    } summ_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        int          fw, mw;
        bit          tk;
        int          cyc;
        logic [3:0]  alu;
        logic [1:0]  wb;
        int          regw, ret, ill, bus;
        logic        pcx;
    } vec_t;

    int   checks = 0;
    int   passed = 0;
    cyc_t exp_q[$];
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic outs_t grab();
        outs_t o;
        o.state = state;       o.pc_write = pc_write;   o.ir_write = ir_write;
        o.mem_req = mem_req;   o.mem_we = mem_we;       o.reg_write = reg_write;
        o.alu = alu_control;   o.src_imm = alu_src_imm; o.wb_sel = wb_sel;
        o.illegal = illegal_instr; o.bus = bus_error;   o.retired = instr_retired;
        return o;
    endfunction

    function automatic outs_t zo(input logic [2:0] st);
        outs_t o = '0;
        o.state = st;
        return o;
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        logic [31:0] w = 32'h0;
        w[6:0] = op; w[11:7] = 5'd10; w[14:12] = f3; w[30] = f7;
        return w;
    endfunction

    function automatic logic [3:0] ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        logic [3:0] base [8];
        base = '{4'h2, 4'h4, 4'h7, 4'h9, 4'h3, 4'h5, 4'h1, 4'h0};
        if (op == 7'h33 || op == 7'h13) begin
            if (f3 == 3'd0 && f7 && op == 7'h33) return 4'h6;
            if (f3 == 3'd5 && f7) return 4'h8;
            return base[f3];
        end
        if (op == 7'h63) return (f3 inside {3'd0, 3'd1}) ? 4'h6 : (f3 inside {3'd4, 3'd5}) ? 4'h7 : 4'h9;
        return 4'h2;
    endfunction

    task automatic push(input logic rdy, input bit any, input outs_t o);
        cyc_t c;
        c.rdy = rdy; c.any = any; c.exp = o;
        exp_q.push_back(c);
    endtask

    // A memory access: w not-ready cycles, then either a completing cycle or a bus-error trap.
    task automatic mem_phase(input int w, input logic [2:0] st, input bit we, input bit fetch,
                             input bit store, output bit ok);
        outs_t o;
        for (int i = 0; i < w && i <= int'(MT); i++) begin
            o = zo(st); o.mem_req = 1'b1; o.mem_we = we;
            push(1'b0, 1'b0, o);
        end
        if (w > int'(MT)) begin
            o = zo(3'd5); o.bus = 1'b1;
            push(1'b0, 1'b1, o);
            ok = 1'b0;
            return;
        end
        o = zo(st); o.mem_req = 1'b1; o.mem_we = we;
        o.ir_write = fetch; o.pc_write = fetch; o.retired = store;
        push(1'b1, 1'b0, o);
        ok = 1'b1;
    endtask

    task automatic build_trace(input logic [31:0] ins, input int fw, input int mw, input bit tk);
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        bit         ok, rt, ia, ld, sw, br, jal, lui;
        outs_t      o;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[30];
        rt = (op == 7'h33); ia = (op == 7'h13); ld = (op == 7'h03); sw = (op == 7'h23);
        br = (op == 7'h63); jal = (op == 7'h6F); lui = (op == 7'h37);
        exp_q.delete();
        mem_phase(fw, 3'd0, 1'b0, 1'b1, 1'b0, ok);
        if (!ok) return;
        push(1'b0, 1'b1, zo(3'd1));
        if (!(rt | ia | ld | sw | br | jal | lui)) begin
            o = zo(3'd5); o.illegal = 1'b1;
            push(1'b0, 1'b1, o);
            return;
        end
        o = zo(3'd2);
        o.alu = ref_alu(op, f3, f7);
        o.src_imm = !(rt | br);
        o.pc_write = jal | (br & tk);
        o.retired = br;
        push(1'b0, 1'b1, o);
        if (br) return;
        if (ld | sw) begin
            mem_phase(mw, 3'd3, sw, 1'b0, sw, ok);
            if (!ok || sw) return;
        end
        o = zo(3'd4); o.reg_write = 1'b1; o.retired = 1'b1;
        o.wb_sel = ld ? 2'd1 : jal ? 2'd2 : lui ? 2'd3 : 2'd0;
        push(1'b0, 1'b1, o);
    endtask

    // Entered at a negedge in the FETCH cycle; returns at the negedge of the next FETCH.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input bit tk,
                             output summ_t s);
        outs_t act;
        s.cyc = 0; s.alu = 4'h0; s.wb = 2'd0; s.regw = 0; s.ret = 0; s.ill = 0; s.bus = 0; s.pcx = 1'b0;
        build_trace(ins, fw, mw, tk);
        opcode = ins[6:0]; funct3 = ins[14:12]; funct7_5 = ins[30]; branch_taken = tk;
        foreach (exp_q[k]) begin
            mem_ready = exp_q[k].any ? 1'($urandom_range(0, 1)) : exp_q[k].rdy;
            #1;
            act = grab();
            check($sformatf("cycle%0d ins=%h", k, ins), 32'(act), 32'(exp_q[k].exp));
            s.cyc++;
            if (act.state == 3'd2) begin s.alu = act.alu; s.pcx = act.pc_write; end
            if (act.reg_write) begin s.regw++; s.wb = act.wb_sel; end
            if (act.retired) s.ret++;
            if (act.illegal) s.ill++;
            if (act.bus)     s.bus++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        summ_t      s;
        logic [6:0] legal_ops [7];
        logic [6:0] bad_ops [5];
        logic [6:0] op;
        logic [2:0] f3;
        int         r, fw, mw;

        legal_ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37};
        bad_ops   = '{7'h7F, 7'h00, 7'h17, 7'h67, 7'h73};

        //                 name       instr                  fw mw tk  cyc alu   wb  rw rt il bu pcx
        tbl.push_back(vec_t'{"ADD",    32'h00B50533,           0, 0, 0,  4, 4'h2, 2'd0, 1, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"SUB",    mk(7'h33, 3'd0, 1'b1),  0, 0, 0,  4, 4'h6, 2'd0, 1, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"SRAI",   mk(7'h13, 3'd5, 1'b1),  0, 0, 0,  4, 4'h8, 2'd0, 1, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"ADDI7",  mk(7'h13, 3'd0, 1'b1),  0, 0, 0,  4, 4'h2, 2'd0, 1, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"LW_W2",  mk(7'h03, 3'd2, 1'b0),  0, 2, 0,  7, 4'h2, 2'd1, 1, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"SW",     mk(7'h23, 3'd2, 1'b0),  0, 0, 0,  4, 4'h2, 2'd0, 0, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"BEQ_T",  mk(7'h63, 3'd0, 1'b0),  0, 0, 1,  3, 4'h6, 2'd0, 0, 1, 0, 0, 1'b1});
        tbl.push_back(vec_t'{"BEQ_N",  mk(7'h63, 3'd0, 1'b0),  0, 0, 0,  3, 4'h6, 2'd0, 0, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"ILLEG",  mk(7'h7F, 3'd0, 1'b0),  0, 0, 0,  3, 4'h0, 2'd0, 0, 0, 1, 0, 1'b0});
        tbl.push_back(vec_t'{"F_TMO",  32'h00B50533,           4, 0, 0,  5, 4'h0, 2'd0, 0, 0, 0, 1, 1'b0});
        tbl.push_back(vec_t'{"F_LIM",  32'h00B50533,           3, 0, 0,  7, 4'h2, 2'd0, 1, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"LUI",    mk(7'h37, 3'd0, 1'b0),  0, 0, 0,  4, 4'h2, 2'd3, 1, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"JAL",    mk(7'h6F, 3'd0, 1'b0),  0, 0, 0,  4, 4'h2, 2'd2, 1, 1, 0, 0, 1'b1});
        tbl.push_back(vec_t'{"SLTU",   mk(7'h33, 3'd3, 1'b0),  0, 0, 0,  4, 4'h9, 2'd0, 1, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"SLT",    mk(7'h33, 3'd2, 1'b0),  0, 0, 0,  4, 4'h7, 2'd0, 1, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"OR",     mk(7'h33, 3'd6, 1'b0),  1, 0, 0,  5, 4'h1, 2'd0, 1, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"AND",    mk(7'h33, 3'd7, 1'b0),  0, 0, 0,  4, 4'h0, 2'd0, 1, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"SRL",    mk(7'h33, 3'd5, 1'b0),  0, 0, 0,  4, 4'h5, 2'd0, 1, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"XORI",   mk(7'h13, 3'd4, 1'b0),  0, 0, 0,  4, 4'h3, 2'd0, 1, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"SLLI",   mk(7'h13, 3'd1, 1'b0),  0, 0, 0,  4, 4'h4, 2'd0, 1, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"BLTU",   mk(7'h63, 3'd6, 1'b0),  0, 0, 0,  3, 4'h9, 2'd0, 0, 1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{"BGE",    mk(7'h63, 3'd5, 1'b0),  0, 0, 1,  3, 4'h7, 2'd0, 0, 1, 0, 0, 1'b1});
        tbl.push_back(vec_t'{"LW_TMO", mk(7'h03, 3'd2, 1'b0),  0, 4, 0,  8, 4'h2, 2'd0, 0, 0, 0, 1, 1'b0});
        tbl.push_back(vec_t'{"SW_LIM", mk(7'h23, 3'd2, 1'b0),  0, 3, 0,  7, 4'h2, 2'd0, 0, 1, 0, 0, 1'b0});

        reset = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0;
        opcode = 7'h0; funct3 = 3'd0; funct7_5 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("reset_hold%0d", k), 32'(grab()), 32'(zo(3'd0)));
        end
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[k]) begin
            run_instr(tbl[k].ins, tbl[k].fw, tbl[k].mw, tbl[k].tk, s);
            check({tbl[k].name, ".cycles"}, 32'(s.cyc),  32'(tbl[k].cyc));
            check({tbl[k].name, ".alu"},    32'(s.alu),  32'(tbl[k].alu));
            check({tbl[k].name, ".wb_sel"}, 32'(s.wb),   32'(tbl[k].wb));
            check({tbl[k].name, ".regw"},   32'(s.regw), 32'(tbl[k].regw));
            check({tbl[k].name, ".retire"}, 32'(s.ret),  32'(tbl[k].ret));
            check({tbl[k].name, ".illeg"},  32'(s.ill),  32'(tbl[k].ill));
            check({tbl[k].name, ".buserr"}, 32'(s.bus),  32'(tbl[k].bus));
            check({tbl[k].name, ".pc_exec"},32'(s.pcx),  32'(tbl[k].pcx));
        end

        // Reset landing in WB must squash the write and the retire.
        opcode = 7'h33; funct3 = 3'd0; funct7_5 = 1'b0; branch_taken = 1'b0;
        mem_ready = 1'b1; #1;
        check("rwb_fetch_state", 32'(state), 32'd0);
        check("rwb_ir_write", 32'(ir_write), 32'd1);
        @(negedge clk); mem_ready = 1'b0; #1;
        check("rwb_decode_state", 32'(state), 32'd1);
        @(negedge clk); #1;
        check("rwb_exec_state", 32'(state), 32'd2);
        @(negedge clk); reset = 1'b1; mem_ready = 1'b1; #1;
        check("rwb_wb_state", 32'(state), 32'd4);
        check("rwb_reg_write", 32'(reg_write), 32'd0);
        check("rwb_retired", 32'(instr_retired), 32'd0);
        @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
        check("rwb_after_state", 32'(state), 32'd0);
        check("rwb_after_mem_req", 32'(mem_req), 32'd1);
        check("rwb_after_reg_write", 32'(reg_write), 32'd0);

        for (int n = 0; n < 200; n++) begin
            op = ($urandom_range(0, 7) == 0) ? bad_ops[$urandom_range(0, 4)] : legal_ops[$urandom_range(0, 6)];
            f3 = 3'($urandom_range(0, 7));
            if (op == 7'h63 && f3[2:1] == 2'b01) f3[2] = 1'b1;
            r  = int'($urandom_range(0, 9));
            fw = (r < 7) ? r % 3 : (r == 9) ? 4 : 3;
            r  = int'($urandom_range(0, 9));
            mw = (r < 7) ? r % 3 : (r == 9) ? 5 : 3;
            run_instr(mk(op, f3, 1'($urandom_range(0, 1))), fw, mw, 1'($urandom_range(0, 1)), s);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
